regfile_ckpt: RTL and testbench
===============================

REGFILE_CKPT -- requirements
Module: regfile_ckpt

Interface
REQ-001 Parameter NUM_RD, default 2: number of read ports (1..4).
REQ-002 Parameter NUM_CKPT, default 4: number of dependency-table checkpoints (power of two, 2..8); CKPT_W = log2(NUM_CKPT).
REQ-003 Parameter XLEN, default 32: register value width; ROB id width is `ROB_WIDTH.
REQ-004 Ports; index i occupies bits [i*W+W-1:i*W] of each flat vector:
 clk_in  in  1  system clock; the block SHALL use one clock.
 rst_in  in  1  reset; SHALL be synchronous and active-low.
 rdy_in  in  1  low: freeze all state.
 clear  in  1  full flush of dependencies.
 commit_ready / commit_reg_id / commit_val / commit_rob_id  in  1/5/XLEN/`ROB_WIDTH  ROB commit.
 issue_reg_ready / issue_reg_rd / issue_rob_id  in  1/5/`ROB_WIDTH  decoder issue.
 get_reg  in  NUM_RD*5  read addresses.
 get_val  out  NUM_RD*XLEN  resolved values.
 has_dep  out  NUM_RD  operand still pending.
 get_dep  out  NUM_RD*`ROB_WIDTH  producing ROB id.
 search_rob_id  out  NUM_RD*`ROB_WIDTH  ROB lookup id (= get_dep).
 search_ready / search_val  in  NUM_RD / NUM_RD*XLEN  ROB lookup result.
 ckpt_save / ckpt_save_id  in  1/CKPT_W  snapshot request.
 ckpt_restore / ckpt_restore_id  in  1/CKPT_W  mispredict recovery.
 ckpt_free / ckpt_free_id  in  1/CKPT_W  release slot.
 ckpt_valid  out  NUM_CKPT  slot occupancy.
 ckpt_err  out  1  one-cycle protocol-error pulse.

Function
REQ-005 Read port i, combinational, pre-update state, priority: reg 0 -> val 0, dep 0; no dep -> stored val; commit_ready and commit_rob_id == dep -> commit_val, no dep; search_ready[i] -> search_val, no dep; else has_dep=1, val 0, get_dep = dep.
REQ-006 Commit with commit_ready=1 and rd!=0 SHALL write val[rd]; without commit_ready val SHALL NOT change.
REQ-007 Commit SHALL clear has_dep[rd] only if dep[rd]==commit_rob_id and no same-cycle issue targets rd.
REQ-008 Issue with rd!=0 SHALL set has_dep[rd]=1, dep[rd]=issue_rob_id; issue wins over commit on the same register.
REQ-009 Register 0 SHALL always read 0 with no dependency.
REQ-010 ckpt_save SHALL store into slot ckpt_save_id the next-state dependency table (after this cycle's issue and commit) and set ckpt_valid.
REQ-011 Each commit SHALL also clear, in every valid checkpoint, the entry for commit_reg_id whose dep equals commit_rob_id.
REQ-012 ckpt_restore on a valid slot SHALL load the table from that slot (with same-cycle commit clearing applied), ignore same-cycle issue and save, and invalidate that slot; other slots unchanged.
REQ-013 Restore on an invalid slot SHALL be ignored and pulse ckpt_err; save to a valid slot SHALL overwrite and pulse ckpt_err.
REQ-014 ckpt_free SHALL clear ckpt_valid[ckpt_free_id]; save to the same slot in the same cycle wins.
REQ-015 clear SHALL zero all has_dep/dep and all ckpt_valid; val retained; restore, issue, save ignored.
REQ-016 Priority: reset > rdy_in low > clear > restore > issue/commit/save/free.
REQ-017 Updates visible at read ports one cycle after the update edge; ckpt_err SHALL be low in any cycle without an error.

Reset
REQ-018 rst_in low at a clock edge SHALL zero all val, dep, has_dep, snapshots, ckpt_valid and ckpt_err, regardless of rdy_in; mid-operation reset discards all pending events.

Structure
REQ-019 XLEN default, CKPT_W derivation and `ROB_WIDTH SHALL live in the shared defines header.
REQ-020 Per-port bypass mux SHALL be sub-module regfile_read_port, generated NUM_RD times.

Verification
REQ-021 Issue x5 rob 3, next cycle read x5 -> has_dep=1, get_dep=3; commit rob 3 val 0xAB same cycle -> get_val=0xAB, has_dep=0.
REQ-022 Issue x7 rob 4, save slot 1, issue x7 rob 6, restore slot 1 -> x7 dep=4, ckpt_valid[1]=0.
REQ-023 Save slot 0 with x9 dep 2, commit rob 2 to x9, restore slot 0 -> x9 no dep, val = commit value.
REQ-024 Restore invalid slot 2 -> ckpt_err one cycle, table unchanged; save to valid slot -> ckpt_err.
REQ-025 Same-cycle commit x4 rob 1 and issue x4 rob 5 -> val[x4] updated, dep=5, has_dep=1.
REQ-026 rdy_in low with issue/commit/save active -> no state change; clear with 3 valid slots -> ckpt_valid=0.

Source files
------------

// File: rtl/regfile_ckpt_pkg.sv
// Shared widths, defines and dependency-table entry type for the checkpointed register file.
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif
`ifndef XLEN_DEFAULT
`define XLEN_DEFAULT 32
`endif

package regfile_ckpt_pkg;

    localparam int unsigned ROB_W    = `ROB_WIDTH;
    localparam int unsigned XLEN_DEF = `XLEN_DEFAULT;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef struct packed {
        logic             busy;
        logic [ROB_W-1:0] rob;
    } dep_t;

    // Checkpoint id width: ceil(log2(n)).
    function automatic int unsigned ckpt_w(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One operand read port: resolves a register through commit and ROB-search bypass.
module regfile_read_port
    import regfile_ckpt_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [REG_W-1:0] reg_id,
    input  dep_t             entry,
    input  logic [XLEN-1:0]  reg_val,
    input  logic             commit_ready,
    input  logic [ROB_W-1:0] commit_rob_id,
    input  logic [XLEN-1:0]  commit_val,
    input  logic             search_ready,
    input  logic [XLEN-1:0]  search_val,
    output logic [XLEN-1:0]  get_val_c,
    output logic             has_dep_c,
    output logic [ROB_W-1:0] get_dep_c
);

    // get_dep tracks the stored producer whenever one exists so the ROB lookup
    // never depends on its own result.
    always_comb begin
        get_val_c = '0;
        has_dep_c = 1'b0;
        get_dep_c = '0;
        if (reg_id == REG_W'(0)) begin
            get_val_c = '0;
        end else if (!entry.busy) begin
            get_val_c = reg_val;
        end else begin
            get_dep_c = entry.rob;
            if (commit_ready && (commit_rob_id == entry.rob)) begin
                get_val_c = commit_val;
            end else if (search_ready) begin
                get_val_c = search_val;
            end else begin
                has_dep_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_ckpt.sv
// Architectural register file with rename dependency table and checkpoint/restore.
module regfile_ckpt
    import regfile_ckpt_pkg::*;
#(
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned NUM_CKPT = 4,
    parameter  int unsigned XLEN     = XLEN_DEF,
    localparam int unsigned CKPT_W   = ckpt_w(NUM_CKPT)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic                     commit_ready,
    input  logic [REG_W-1:0]         commit_reg_id,
    input  logic [XLEN-1:0]          commit_val,
    input  logic [ROB_W-1:0]         commit_rob_id,
    input  logic                     issue_reg_ready,
    input  logic [REG_W-1:0]         issue_reg_rd,
    input  logic [ROB_W-1:0]         issue_rob_id,
    input  logic [NUM_RD*REG_W-1:0]  get_reg,
    output logic [NUM_RD*XLEN-1:0]   get_val,
    output logic [NUM_RD-1:0]        has_dep,
    output logic [NUM_RD*ROB_W-1:0]  get_dep,
    output logic [NUM_RD*ROB_W-1:0]  search_rob_id,
    input  logic [NUM_RD-1:0]        search_ready,
    input  logic [NUM_RD*XLEN-1:0]   search_val,
    input  logic                     ckpt_save,
    input  logic [CKPT_W-1:0]        ckpt_save_id,
    input  logic                     ckpt_restore,
    input  logic [CKPT_W-1:0]        ckpt_restore_id,
    input  logic                     ckpt_free,
    input  logic [CKPT_W-1:0]        ckpt_free_id,
    output logic [NUM_CKPT-1:0]      ckpt_valid,
    output logic                     ckpt_err
);

    logic [XLEN-1:0]     val_q  [NUM_REGS];
    logic [XLEN-1:0]     val_d  [NUM_REGS];
    dep_t                tbl_q  [NUM_REGS];
    dep_t                tbl_d  [NUM_REGS];
    dep_t                snap_q [NUM_CKPT][NUM_REGS];
    dep_t                snap_d [NUM_CKPT][NUM_REGS];
    logic [NUM_CKPT-1:0] ckpt_valid_q, ckpt_valid_d;
    logic                ckpt_err_q, ckpt_err_d;

    always_comb begin
        val_d        = val_q;
        tbl_d        = tbl_q;
        snap_d       = snap_q;
        ckpt_valid_d = ckpt_valid_q;
        ckpt_err_d   = 1'b0;
        if (rdy_in) begin
            if (clear) begin
                tbl_d        = '{default: '0};
                ckpt_valid_d = '0;
            end else begin
                // Commit retires the producer in the live table and every live snapshot.
                if (commit_ready && (commit_reg_id != REG_W'(0))) begin
                    val_d[commit_reg_id] = commit_val;
                    if (tbl_q[commit_reg_id].busy && (tbl_q[commit_reg_id].rob == commit_rob_id))
                        tbl_d[commit_reg_id].busy = 1'b0;
                    for (int unsigned s = 0; s < NUM_CKPT; s++) begin
                        if (ckpt_valid_q[CKPT_W'(s)] && snap_q[CKPT_W'(s)][commit_reg_id].busy &&
                            (snap_q[CKPT_W'(s)][commit_reg_id].rob == commit_rob_id))
                            snap_d[CKPT_W'(s)][commit_reg_id].busy = 1'b0;
                    end
                end
                if (ckpt_restore && ckpt_valid_q[ckpt_restore_id]) begin
                    tbl_d                         = snap_d[ckpt_restore_id];
                    ckpt_valid_d[ckpt_restore_id] = 1'b0;
                    if (ckpt_free) ckpt_valid_d[ckpt_free_id] = 1'b0;
                end else begin
                    if (ckpt_restore) ckpt_err_d = 1'b1;
                    if (issue_reg_ready && (issue_reg_rd != REG_W'(0))) begin
                        tbl_d[issue_reg_rd].busy = 1'b1;
                        tbl_d[issue_reg_rd].rob  = issue_rob_id;
                    end
                    if (ckpt_free) ckpt_valid_d[ckpt_free_id] = 1'b0;
                    if (ckpt_save) begin
                        if (ckpt_valid_q[ckpt_save_id]) ckpt_err_d = 1'b1;
                        snap_d[ckpt_save_id]       = tbl_d;
                        ckpt_valid_d[ckpt_save_id] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            val_q        <= '{default: '0};
            tbl_q        <= '{default: '0};
            snap_q       <= '{default: '{default: '0}};
            ckpt_valid_q <= '0;
            ckpt_err_q   <= 1'b0;
        end else begin
            val_q        <= val_d;
            tbl_q        <= tbl_d;
            snap_q       <= snap_d;
            ckpt_valid_q <= ckpt_valid_d;
            ckpt_err_q   <= ckpt_err_d;
        end
    end

    assign ckpt_valid    = ckpt_valid_q;
    assign ckpt_err      = ckpt_err_q;
    assign search_rob_id = get_dep;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(.XLEN(XLEN)) u_port (
            .reg_id        (get_reg[i*REG_W +: REG_W]),
            .entry         (tbl_q[get_reg[i*REG_W +: REG_W]]),
            .reg_val       (val_q[get_reg[i*REG_W +: REG_W]]),
            .commit_ready  (commit_ready),
            .commit_rob_id (commit_rob_id),
            .commit_val    (commit_val),
            .search_ready  (search_ready[i]),
            .search_val    (search_val[i*XLEN +: XLEN]),
            .get_val_c     (get_val[i*XLEN +: XLEN]),
            .has_dep_c     (has_dep[i]),
            .get_dep_c     (get_dep[i*ROB_W +: ROB_W])
        );
    end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Directed scoreboard bench for regfile_ckpt: stimulus queues expectations, a monitor checks them.
module tb_regfile_ckpt;

    localparam int unsigned NRD = 2;
    localparam int unsigned NCK = 4;
    localparam int unsigned XL  = 32;
    localparam int unsigned RW  = regfile_ckpt_pkg::ROB_W;
    localparam int unsigned CW  = 2;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             clear;
    logic             commit_ready;
    logic [4:0]       commit_reg_id;
    logic [XL-1:0]    commit_val;
    logic [RW-1:0]    commit_rob_id;
    logic             issue_reg_ready;
    logic [4:0]       issue_reg_rd;
    logic [RW-1:0]    issue_rob_id;
    logic [NRD*5-1:0] get_reg;
    logic [NRD*XL-1:0] get_val;
    logic [NRD-1:0]   has_dep;
    logic [NRD*RW-1:0] get_dep;
    logic [NRD*RW-1:0] search_rob_id;
    logic [NRD-1:0]   search_ready;
    logic [NRD*XL-1:0] search_val;
    logic             ckpt_save;
    logic [CW-1:0]    ckpt_save_id;
    logic             ckpt_restore;
    logic [CW-1:0]    ckpt_restore_id;
    logic             ckpt_free;
    logic [CW-1:0]    ckpt_free_id;
    logic [NCK-1:0]   ckpt_valid;
    logic             ckpt_err;

    regfile_ckpt #(.NUM_RD(NRD), .NUM_CKPT(NCK), .XLEN(XL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .commit_ready(commit_ready), .commit_reg_id(commit_reg_id),
        .commit_val(commit_val), .commit_rob_id(commit_rob_id),
        .issue_reg_ready(issue_reg_ready), .issue_reg_rd(issue_reg_rd),
        .issue_rob_id(issue_rob_id), .get_reg(get_reg), .get_val(get_val),
        .has_dep(has_dep), .get_dep(get_dep), .search_rob_id(search_rob_id),
        .search_ready(search_ready), .search_val(search_val),
        .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
        .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
        .ckpt_free(ckpt_free), .ckpt_free_id(ckpt_free_id),
        .ckpt_valid(ckpt_valid), .ckpt_err(ckpt_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string         name;
        logic [XL-1:0] v0;
        logic          h0;
        logic [RW-1:0] d0;
        logic [XL-1:0] v1;
        logic          h1;
        logic [RW-1:0] d1;
        logic [3:0]    cv;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    logic chk_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t mk(input string n, input logic [XL-1:0] v0, input logic h0, input int d0,
                                input logic [XL-1:0] v1, input logic h1, input int d1,
                                input logic [3:0] cv, input logic err);
        exp_t e;
        e.name = n; e.v0 = v0; e.h0 = h0; e.d0 = RW'(d0);
        e.v1 = v1; e.h1 = h1; e.d1 = RW'(d1); e.cv = cv; e.err = err;
        return e;
    endfunction

    // Monitor: whenever the bench marks a cycle as observed, pop and compare.
    always @(negedge clk_in) begin
        exp_t e;
        if (chk_en) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL monitor: outputs presented with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                if (get_val[XL-1:0] !== e.v0 || has_dep[0] !== e.h0 || get_dep[RW-1:0] !== e.d0 ||
                    get_val[2*XL-1:XL] !== e.v1 || has_dep[1] !== e.h1 || get_dep[2*RW-1:RW] !== e.d1 ||
                    search_rob_id !== get_dep || search_rob_id[RW-1:0] !== e.d0 ||
                    ckpt_valid !== e.cv || ckpt_err !== e.err) begin
                    miscompares++;
                    $display("FAIL %s: got v0=%h h0=%b d0=%0d v1=%h h1=%b d1=%0d srch=%h cv=%b err=%b; want v0=%h h0=%b d0=%0d v1=%h h1=%b d1=%0d cv=%b err=%b",
                             e.name, get_val[XL-1:0], has_dep[0], get_dep[RW-1:0],
                             get_val[2*XL-1:XL], has_dep[1], get_dep[2*RW-1:RW], search_rob_id,
                             ckpt_valid, ckpt_err, e.v0, e.h0, e.d0, e.v1, e.h1, e.d1, e.cv, e.err);
                end
            end
        end
    end

    task automatic idle();
        rdy_in = 1'b1; clear = 1'b0;
        commit_ready = 1'b0; commit_reg_id = '0; commit_val = '0; commit_rob_id = '0;
        issue_reg_ready = 1'b0; issue_reg_rd = '0; issue_rob_id = '0;
        search_ready = '0; search_val = '0;
        ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
        ckpt_free = 1'b0; ckpt_free_id = '0;
        chk_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic rd(input int r0, input int r1);
        get_reg = {5'(r1), 5'(r0)};
    endtask

    task automatic iss(input int r, input int rob);
        issue_reg_ready = 1'b1; issue_reg_rd = 5'(r); issue_rob_id = RW'(rob);
    endtask

    task automatic cmt(input int r, input int rob, input logic [XL-1:0] v);
        commit_ready = 1'b1; commit_reg_id = 5'(r); commit_rob_id = RW'(rob); commit_val = v;
    endtask

    task automatic save(input int s);
        ckpt_save = 1'b1; ckpt_save_id = CW'(s);
    endtask

    task automatic restore(input int s);
        ckpt_restore = 1'b1; ckpt_restore_id = CW'(s);
    endtask

    task automatic chk(input exp_t e);
        exp_q.push_back(e);
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_in = 1'b0;
        rd(0, 0);
        iss(1, 1);
        #1;
        tick(); tick();

        rst_in = 1'b1; rd(0, 5); iss(5, 3);
        chk(mk("reset", 0, 0, 0, 0, 0, 0, 4'b0000, 0)); tick();
        rd(5, 0); chk(mk("issue_dep", 0, 1, 3, 0, 0, 0, 4'b0000, 0)); tick();
        rd(5, 0); cmt(5, 3, 32'hAB);
        chk(mk("commit_bypass", 32'hAB, 0, 3, 0, 0, 0, 4'b0000, 0)); tick();
        rd(5, 0); chk(mk("commit_written", 32'hAB, 0, 0, 0, 0, 0, 4'b0000, 0)); tick();

        iss(6, 7); tick();
        rd(6, 6); search_ready = 2'b01; search_val = {32'h0, 32'h55};
        chk(mk("search_bypass", 32'h55, 0, 7, 0, 1, 7, 4'b0000, 0)); tick();

        iss(7, 4); tick();
        save(1); tick();
        iss(7, 6); rd(7, 6); chk(mk("save_valid", 0, 1, 4, 0, 1, 7, 4'b0010, 0)); tick();
        restore(1); rd(7, 6); chk(mk("pre_restore", 0, 1, 6, 0, 1, 7, 4'b0010, 0)); tick();
        rd(7, 6); chk(mk("restore_dep", 0, 1, 4, 0, 1, 7, 4'b0000, 0)); tick();

        iss(9, 2); tick();
        save(0); tick();
        rd(9, 7); cmt(9, 2, 32'h1234);
        chk(mk("commit_ckpt_bypass", 32'h1234, 0, 2, 0, 1, 4, 4'b0001, 0)); tick();
        iss(9, 8); tick();
        restore(0); rd(9, 7); chk(mk("pre_restore_live", 0, 1, 8, 0, 1, 4, 4'b0001, 0)); tick();
        rd(9, 7); chk(mk("restore_committed", 32'h1234, 0, 0, 0, 1, 4, 4'b0000, 0)); tick();

        restore(2); tick();
        rd(9, 7); chk(mk("err_restore_invalid", 32'h1234, 0, 0, 0, 1, 4, 4'b0000, 1)); tick();
        rd(9, 7); save(3); chk(mk("err_one_cycle", 32'h1234, 0, 0, 0, 1, 4, 4'b0000, 0)); tick();
        save(3); tick();
        rd(9, 7); ckpt_free = 1'b1; ckpt_free_id = 2'd3;
        chk(mk("err_save_valid", 32'h1234, 0, 0, 0, 1, 4, 4'b1000, 1)); tick();
        rd(9, 7); chk(mk("free", 32'h1234, 0, 0, 0, 1, 4, 4'b0000, 0)); tick();

        iss(4, 1); tick();
        cmt(4, 1, 32'h44); iss(4, 5); tick();
        rd(4, 9); chk(mk("issue_wins", 0, 1, 5, 32'h1234, 0, 0, 4'b0000, 0)); tick();

        save(0); tick();
        save(1); tick();
        save(2); tick();
        rdy_in = 1'b0; iss(4, 10); cmt(4, 5, 32'h77); save(3); tick();
        rd(4, 9); chk(mk("rdy_freeze", 0, 1, 5, 32'h1234, 0, 0, 4'b0111, 0)); tick();
        clear = 1'b1; iss(9, 3); tick();
        rd(4, 9); chk(mk("clear", 32'h44, 0, 0, 32'h1234, 0, 0, 4'b0000, 0)); tick();

        iss(3, 2); save(0); rst_in = 1'b0; tick();
        rst_in = 1'b1; rd(3, 4); chk(mk("mid_reset", 0, 0, 0, 0, 0, 0, 4'b0000, 0));
        cmt(0, 0, 32'hFF); iss(0, 1); tick();
        rd(0, 4); chk(mk("x0_hardwired", 0, 0, 0, 0, 0, 0, 4'b0000, 0)); tick();
        tick();

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d expectations never observed, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
